// File: rtl/vga_trace_pkg.sv
// vga_trace_pkg: shared types, defaults and colors for the VGA trace engine
package vga_trace_pkg;
  typedef logic [11:0] color_t;
  typedef enum logic [1:0] {CLEAR, DRAW, HOLD} state_t;
  localparam int DEF_WIDTH = 160;
  localparam int DEF_HEIGHT = 120;
  localparam int DEF_HOLD = 10008;
  localparam color_t COLOR_BLACK = 12'h000;
  localparam color_t COLOR_GREEN = 12'h0F0;
  localparam color_t COLOR_WHITE = 12'hFFF;
endpackage

// File: rtl/vga_trace_engine_if.sv
// vga_trace_engine_if: ADC sample input and framebuffer write port of the trace engine
interface vga_trace_engine_if;
  logic clk_en;
  logic [13:0] adc_data;
  logic adc_valid;
  logic [7:0] CounterX;
  logic [7:0] CounterY;
  vga_trace_pkg::color_t color;
  logic pix_we;
  logic frame_done;
  modport master(input clk_en, adc_data, adc_valid, output CounterX, CounterY, color, pix_we, frame_done);
  modport slave(output clk_en, adc_data, adc_valid, input CounterX, CounterY, color, pix_we, frame_done);
endinterface

// File: rtl/vga_trace_engine_scaler.sv
// trace_scaler: maps a 14-bit ADC sample to a screen row, full scale at the top
module trace_scaler
  import vga_trace_pkg::*;
#(
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic [13:0] adc_data,
  output logic [7:0]  row
);
  logic [15:0] prod;
  logic unused_bits;
  assign prod = 16'(adc_data[13:6]) * 16'(HEIGHT);
  assign row = 8'(HEIGHT - 1) - prod[15:8];
  assign unused_bits = ^{adc_data[5:0], prod[7:0]};
endmodule

// File: rtl/vga_trace_engine.sv
// vga_trace_engine: per-frame clear, trace plot and hold sequencer for the framebuffer.
// Define VGA_TRACE_LINE_FILL_EN to join consecutive samples with vertical line segments.
module vga_trace_engine
  import vga_trace_pkg::*;
#(
  parameter int     WIDTH       = DEF_WIDTH,
  parameter int     HEIGHT      = DEF_HEIGHT,
  parameter int     HOLD_CYCLES = DEF_HOLD,
  parameter color_t BG_COLOR    = COLOR_BLACK,
  parameter color_t TRACE_COLOR = COLOR_GREEN
) (
  input logic clk,
  input logic rst_n,
  vga_trace_engine_if.master bus
);
  localparam logic [7:0]  X_MAX = 8'(WIDTH - 1);
  localparam logic [7:0]  Y_MAX = 8'(HEIGHT - 1);
  localparam logic [31:0] H_MAX = 32'(HOLD_CYCLES - 1);
  state_t state_q, state_d;
  logic [7:0] x_q, x_d, y_q, y_d, cx_q, cx_d, cy_q, cy_d, row;
  logic [31:0] hold_q, hold_d;
  color_t col_q, col_d;
  logic we_q, we_d, done_q, done_d, adv;
  trace_scaler #(.HEIGHT(HEIGHT)) u_scaler (.adc_data(bus.adc_data), .row(row));
`ifdef VGA_TRACE_LINE_FILL_EN
  logic fill_q, fill_d;
  logic [7:0] prev_q, prev_d, fy_q, fy_d, fend_q, fend_d, lo, hi;
  // column 0 has no predecessor, so it collapses to a single-pixel segment
  assign lo = (x_q == 8'd0) ? row : (row < prev_q ? row : prev_q);
  assign hi = (x_q == 8'd0) ? row : (row < prev_q ? prev_q : row);
`endif
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    hold_d = hold_q;
    cx_d = '0;
    cy_d = '0;
    col_d = '0;
    we_d = 1'b0;
    done_d = 1'b0;
    adv = 1'b0;
`ifdef VGA_TRACE_LINE_FILL_EN
    fill_d = fill_q;
    prev_d = prev_q;
    fy_d = fy_q;
    fend_d = fend_q;
`endif
    if (bus.clk_en) begin
      case (state_q)
        CLEAR: begin
          we_d = 1'b1;
          cx_d = x_q;
          cy_d = y_q;
          col_d = BG_COLOR;
          x_d = (x_q == X_MAX) ? 8'd0 : x_q + 8'd1;
          y_d = (x_q != X_MAX) ? y_q : (y_q == Y_MAX) ? 8'd0 : y_q + 8'd1;
          state_d = (x_q == X_MAX && y_q == Y_MAX) ? DRAW : CLEAR;
`ifdef VGA_TRACE_LINE_FILL_EN
          prev_d = '0;
          fill_d = 1'b0;
`endif
        end
        DRAW: begin
`ifdef VGA_TRACE_LINE_FILL_EN
          if (fill_q) begin
            we_d = 1'b1;
            cx_d = x_q;
            cy_d = fy_q;
            col_d = TRACE_COLOR;
            fy_d = fy_q + 8'd1;
            fill_d = (fy_q != fend_q);
            adv = (fy_q == fend_q);
          end else if (bus.adc_valid) begin
            we_d = 1'b1;
            cx_d = x_q;
            cy_d = lo;
            col_d = TRACE_COLOR;
            prev_d = row;
            fy_d = lo + 8'd1;
            fend_d = hi;
            fill_d = (lo != hi);
            adv = (lo == hi);
          end
`else
          if (bus.adc_valid) begin
            we_d = 1'b1;
            cx_d = x_q;
            cy_d = row;
            col_d = TRACE_COLOR;
            adv = 1'b1;
          end
`endif
        end
        HOLD: begin
          hold_d = (hold_q == H_MAX) ? '0 : hold_q + 32'd1;
          done_d = (hold_q == H_MAX);
          state_d = (hold_q == H_MAX) ? CLEAR : HOLD;
        end
        default: state_d = CLEAR;
      endcase
      if (adv) begin
        x_d = (x_q == X_MAX) ? 8'd0 : x_q + 8'd1;
        state_d = (x_q == X_MAX) ? HOLD : DRAW;
      end
    end
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= CLEAR;
      x_q <= '0;
      y_q <= '0;
      hold_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      col_q <= '0;
      we_q <= 1'b0;
      done_q <= 1'b0;
`ifdef VGA_TRACE_LINE_FILL_EN
      fill_q <= 1'b0;
      prev_q <= '0;
      fy_q <= '0;
      fend_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      hold_q <= hold_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      col_q <= col_d;
      we_q <= we_d;
      done_q <= done_d;
`ifdef VGA_TRACE_LINE_FILL_EN
      fill_q <= fill_d;
      prev_q <= prev_d;
      fy_q <= fy_d;
      fend_q <= fend_d;
`endif
    end
  end
  assign bus.CounterX = cx_q;
  assign bus.CounterY = cy_q;
  assign bus.color = col_q;
  assign bus.pix_we = we_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_vga_trace_engine.sv
// tb_vga_trace_engine: directed checks of clear raster, scaling, hold, gating, reset and fill
module tb_vga_trace_engine;
  import vga_trace_pkg::*;
  localparam color_t BG = 12'h000;
  localparam color_t TR = 12'h0F0;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  vga_trace_engine_if bus();
  vga_trace_engine #(
    .WIDTH(4), .HEIGHT(3), .HOLD_CYCLES(5), .BG_COLOR(BG), .TRACE_COLOR(TR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] outs;
    return {2'b00, bus.pix_we, bus.frame_done, bus.CounterX, bus.CounterY, bus.color};
  endfunction
  task automatic pix(input string tag, input int x, input int y, input color_t c);
    step;
    check(tag, outs(), {2'b00, 1'b1, 1'b0, 8'(x), 8'(y), c});
  endtask
  task automatic idle(input string tag, input logic done);
    step;
    check(tag, outs(), {2'b00, 1'b0, done, 28'h0});
  endtask
  task automatic sample(input logic [13:0] d);
    bus.adc_data = d;
    bus.adc_valid = 1'b1;
  endtask
  initial begin
    bus.clk_en = 1'b1;
    bus.adc_valid = 1'b0;
    bus.adc_data = '0;
    #1;
    check("reset_outputs", outs(), 32'h0);
    step;
    step;
    check("reset_held", outs(), 32'h0);
    rst_n = 1'b0;
    bus.adc_valid = 1'b1;
    bus.adc_data = 14'h3FFF;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) pix($sformatf("clear_%0d_%0d", x, y), x, y, BG);
    bus.adc_valid = 1'b0;
    idle("draw_wait_idle", 1'b0);
    sample(14'h3FFF);
    pix("draw_3fff", 0, 0, TR);
    sample(14'h0000);
    pix("draw_0000", 1, 2, TR);
    sample(14'h2000);
    pix("draw_2000_row1", 2, 1, TR);
    sample(14'h3FFF);
    pix("draw_last_col", 3, 0, TR);
    for (int i = 1; i <= 5; i++) idle($sformatf("hold_%0d", i), i == 5);
    bus.adc_valid = 1'b0;
    pix("frame2_first", 0, 0, BG);
    pix("frame2_1_0", 1, 0, BG);
    bus.clk_en = 1'b0;
    for (int i = 0; i < 3; i++) idle($sformatf("gated_%0d", i), 1'b0);
    bus.clk_en = 1'b1;
    pix("resume_2_0", 2, 0, BG);
    pix("resume_3_0", 3, 0, BG);
    for (int y = 1; y < 3; y++)
      for (int x = 0; x < 4; x++) pix($sformatf("clear2_%0d_%0d", x, y), x, y, BG);
    sample(14'h0000);
    pix("frame2_draw0", 0, 2, TR);
    #3;
    rst_n = 1'b1;
    #1;
    check("async_reset_outputs", outs(), 32'h0);
    bus.adc_valid = 1'b0;
    step;
    check("reset_mid_draw_held", outs(), 32'h0);
    rst_n = 1'b0;
    pix("restart_clear", 0, 0, BG);
    for (int i = 1; i < 12; i++) pix($sformatf("clear3_%0d", i), i % 4, i / 4, BG);
    sample(14'h0000);
    pix("col0_row2", 0, 2, TR);
    sample(14'h3FFF);
`ifdef VGA_TRACE_LINE_FILL_EN
    pix("fill_1_0", 1, 0, TR);
    sample(14'h2000);
    pix("fill_1_1", 1, 1, TR);
    pix("fill_1_2", 1, 2, TR);
    sample(14'h0000);
    pix("fill_2_0", 2, 0, TR);
    pix("fill_2_1", 2, 1, TR);
    pix("fill_2_2", 2, 2, TR);
`else
    pix("col1_row0", 1, 0, TR);
    sample(14'h2000);
    pix("col2_row1", 2, 1, TR);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_trace_engine.md
# vga_trace_engine

Frame-sequencing pixel writer for the oscilloscope-style VGA display. Each frame it clears the framebuffer, plots one ADC sample per column as a trace, then holds for a fixed interval before starting again. It drives a single-port framebuffer write interface (coordinates, RGB444 color, write strobe) and sits between the ADC capture path and the VGA framebuffer.

## Interface
- `WIDTH`, default 160: columns. Valid range 2..256.
- `HEIGHT`, default 120: rows. Valid range 2..256.
- `HOLD_CYCLES`, default 10008: idle cycles after drawing. Must be at least 1.
- `BG_COLOR`, default 12'h000: clear color.
- `TRACE_COLOR`, default 12'h0F0: trace color.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous, active-high. The port name is historical; logic 1 resets.
- `clk_en` input 1: advance enable. When low, all state freezes and `pix_we` is 0.
- `adc_data` input 14: unsigned ADC sample, synchronous to `clk`.
- `adc_valid` input 1: `adc_data` is valid this cycle.
- `CounterX` output 8: pixel column.
- `CounterY` output 8: pixel row; row 0 is the top.
- `color` output 12: pixel color, RGB444.
- `pix_we` output 1: framebuffer write strobe.
- `frame_done` output 1: one-cycle pulse at the end of HOLD.

## Operation
- States: CLEAR → DRAW → HOLD → CLEAR.
- **Reset:** state CLEAR. All counters 0. `CounterX`/`CounterY`/`color`/`pix_we`/`frame_done` are 0.
- **CLEAR:** raster write of `BG_COLOR`. X is the inner loop (0..WIDTH-1) and Y the outer loop (0..HEIGHT-1). One pixel per enabled cycle, WIDTH*HEIGHT writes. After the write of (WIDTH-1, HEIGHT-1) the state goes to DRAW.
- **DRAW:** column x runs 0..WIDTH-1.
  - On `adc_valid && clk_en`, compute s = `adc_data[13:6]` and row = HEIGHT-1 - ((s*HEIGHT)>>8). The product is 16 bits; the result is always 0..HEIGHT-1.
  - Write (x, row) in `TRACE_COLOR`, then x increments.
  - After column WIDTH-1 is written, the state goes to HOLD.
  - `adc_valid` is ignored when it is not being waited on.
- **HOLD:** `pix_we` is 0.
  - Count HOLD_CYCLES enabled cycles.
  - On the last one, pulse `frame_done` and go to CLEAR.
- **Idle outputs:** when `pix_we` is 0, `CounterX`, `CounterY` and `color` are driven to 0. Outputs are never tri-stated.
- **Reset mid-frame:** asynchronous return to the reset state. The frame restarts with CLEAR.

## Timing
- All outputs are registered.
- The first CLEAR write appears on the first enabled edge after reset deasserts, i.e. `pix_we` is high in the following cycle.
- Sample-to-pixel latency is 1 cycle: `adc_valid` accepted at edge n gives `pix_we` = 1 with that pixel after edge n.
- `clk_en` low stalls the machine mid-raster or mid-hold with no skipped or duplicated pixels. Samples presented while `clk_en` is low are dropped.
- Frame length with `adc_valid` held high and line fill off: WIDTH*HEIGHT + WIDTH + HOLD_CYCLES enabled cycles.

## Configuration
- Macro: `VGA_TRACE_LINE_FILL_EN`.
- **Defined:** for columns x ≥ 1, after a sample is accepted the block writes every row from min(prev_row, row) to max(prev_row, row) inclusive at column x, one pixel per enabled cycle, in ascending row order.
  - `adc_valid` is ignored during the fill.
  - Column 0 writes a single pixel.
  - prev_row is cleared at the start of DRAW.
- **Undefined:** a single pixel per column. No prev_row register exists.

## Structure
- Package `vga_trace_pkg`:
  - state enum (CLEAR, DRAW, HOLD)
  - default WIDTH/HEIGHT/HOLD_CYCLES
  - RGB444 color constants
  - the 12-bit color typedef
- One sub-module, `trace_scaler`: combinational mapping of the 14-bit sample to a row using the formula above, parameterized by HEIGHT.
- The FSM, raster counters, hold counter and optional fill logic sit in `vga_trace_engine`.

## Test plan
All scenarios use WIDTH=4, HEIGHT=3, HOLD_CYCLES=5 and `clk_en`=1 unless stated otherwise.
- **Clear raster:** release reset → 12 writes of color 0 in order (0,0),(1,0),(2,0),(3,0),(0,1)…(3,2), then DRAW.
- **Draw scaling:** `adc_data` 14'h3FFF, 14'h0000, 14'h2000, 14'h3FFF, each with `adc_valid` → writes (0,0),(1,2),(2,1),(3,0) in 12'h0F0.
  - Check: s=128 gives (128*3)>>8=1, so row 1.
- **Hold and frame boundary:** after the draw → exactly 5 cycles with `pix_we` = 0, a single `frame_done` pulse on the 5th, then the CLEAR write at (0,0).
- **clk_en gating:** drop `clk_en` for 3 cycles mid-CLEAR after (1,0) → no writes during the gap, resume at (2,0), total clear writes still 12.
- **Asynchronous reset:** assert `rst_n` mid-DRAW between edges → outputs go to 0 immediately; after release, CLEAR restarts at (0,0).
- **Line fill (macro defined):** rows 2 then 0 in columns 0 and 1 → column 1 writes (1,0),(1,1),(1,2) in that order, and an `adc_valid` during the fill is ignored.
